// File: rtl/sample_req_server.sv
// sample_req_server: queues slot read requests, issues them to the sample RAM with loader-write priority,
// and returns each word tagged with its slot ID in issue order.
module sample_req_server #(
    parameter int ADDR_W      = 23,
    parameter int ID_W        = 6,
    parameter int FIFO_LOG2   = 3,
    parameter int RAM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_available,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ID_W-1:0]   req_id,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    output logic              ram_wr_en,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    output logic [15:0]       data_out,
    output logic [ID_W-1:0]   r_id_out,
    output logic              data_ready,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        drop_count
);
    localparam int DEPTH  = 1 << FIFO_LOG2;
    localparam int STAGES = RAM_LATENCY + 1;
    localparam logic [FIFO_LOG2:0] FULL = (FIFO_LOG2 + 1)'(DEPTH);

    logic [ADDR_W-1:0]    r_q_addr [DEPTH];
    logic [ID_W-1:0]      r_q_id   [DEPTH];
    logic [FIFO_LOG2-1:0] r_wptr;
    logic [FIFO_LOG2-1:0] r_rptr;
    logic [FIFO_LOG2:0]   r_count;
    logic [STAGES-1:0]    r_fl_vld;
    logic [ID_W-1:0]      r_fl_id  [STAGES];
    logic [ADDR_W-1:0]    r_ram_addr;
    logic                 r_ram_rd;
    logic                 r_ram_wr;
    logic [15:0]          r_ram_wdata;
    logic [15:0]          r_dout;
    logic [ID_W-1:0]      r_rid;
    logic                 r_rdy;
    logic                 r_ovf;
    logic [7:0]           r_drops;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    // a full queue still accepts a request when the head leaves in the same cycle
    assign w_pop  = !wr_en && (r_count != '0);
    assign w_push = req_available && ((r_count != FULL) || w_pop);
    assign w_drop = req_available && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wptr] <= req_addr;
            r_q_id[r_wptr]   <= req_id;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_drops <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (FIFO_LOG2 + 1)'(w_push) - (FIFO_LOG2 + 1)'(w_pop);
            if (w_drop) begin
                r_ovf   <= 1'b1;
                r_drops <= (r_drops == 8'hFF) ? r_drops : r_drops + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ram_addr  <= '0;
            r_ram_rd    <= 1'b0;
            r_ram_wr    <= 1'b0;
            r_ram_wdata <= '0;
        end else if (wr_en) begin
            r_ram_addr  <= wr_addr;
            r_ram_rd    <= 1'b0;
            r_ram_wr    <= 1'b1;
            r_ram_wdata <= wr_data;
        end else begin
            r_ram_addr <= w_pop ? r_q_addr[r_rptr] : r_ram_addr;
            r_ram_rd   <= w_pop;
            r_ram_wr   <= 1'b0;
        end
    end

    // in-flight tags travel alongside the RAM read so the tail lines up with valid read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fl_vld <= '0;
            for (int i = 0; i < STAGES; i++) r_fl_id[i] <= '0;
            r_rdy  <= 1'b0;
            r_dout <= '0;
            r_rid  <= '0;
        end else begin
            r_fl_vld   <= {r_fl_vld[STAGES-2:0], w_pop};
            r_fl_id[0] <= r_q_id[r_rptr];
            for (int i = 1; i < STAGES; i++) r_fl_id[i] <= r_fl_id[i-1];
            r_rdy <= r_fl_vld[STAGES-1];
            if (r_fl_vld[STAGES-1]) begin
                r_dout <= ram_rdata;
                r_rid  <= r_fl_id[STAGES-1];
            end
        end
    end

    assign ram_addr   = r_ram_addr;
    assign ram_rd_en  = r_ram_rd;
    assign ram_wr_en  = r_ram_wr;
    assign ram_wdata  = r_ram_wdata;
    assign data_out   = r_dout;
    assign r_id_out   = r_rid;
    assign data_ready = r_rdy;
    assign busy       = (r_count != '0) | (|r_fl_vld);
    assign overflow   = r_ovf;
    assign drop_count = r_drops;
endmodule

// File: tb/tb_sample_req_server.sv
// tb_sample_req_server: directed and random requests checked cycle by cycle against a queue-based reference model.
module tb_sample_req_server;
    localparam int L     = 2;
    localparam int DEPTH = 8;

    typedef struct {logic [22:0] addr; logic [5:0] id;} rq_t;
    typedef struct {int ret; logic [5:0] id; logic [22:0] addr;} ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_available;
    logic [22:0] req_addr;
    logic [5:0]  req_id;
    logic        wr_en;
    logic [22:0] wr_addr;
    logic [15:0] wr_data;
    logic [22:0] ram_addr;
    logic        ram_rd_en;
    logic        ram_wr_en;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [15:0] data_out;
    logic [5:0]  r_id_out;
    logic        data_ready;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_count;

    logic [22:0] ra [0:L-1];
    rq_t         q[$];
    ev_t         ev[$];
    int          cyc;
    int          n_vec;
    int          n_err;
    logic        e_rd, e_wr, e_rdy, e_ovf;
    logic [22:0] e_addr;
    logic [15:0] e_wdata, e_dout;
    logic [5:0]  e_id;
    logic [7:0]  e_drops;

    sample_req_server dut (
        .clk(clk), .reset(reset), .req_available(req_available), .req_addr(req_addr), .req_id(req_id),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .ram_addr(ram_addr), .ram_rd_en(ram_rd_en),
        .ram_wr_en(ram_wr_en), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .data_out(data_out),
        .r_id_out(r_id_out), .data_ready(data_ready), .busy(busy), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input logic [22:0] a);
        return a[15:0] ^ {a[22:16], 9'h000} ^ 16'hA5C3;
    endfunction

    // RAM stand-in: data for the address registered with the read appears L cycles later
    always @(posedge clk) begin
        ra[0] <= ram_addr;
        for (int k = 1; k < L; k++) ra[k] <= ra[k-1];
    end
    assign ram_rdata = word(ra[L-1]);

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
        n_vec++;
        assert (o === x) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, o, x, cyc);
        end
    endtask

    task automatic check_all();
        chk("ram_rd_en", 32'(ram_rd_en), 32'(e_rd));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(e_wr));
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
        chk("data_ready", 32'(data_ready), 32'(e_rdy));
        chk("data_out", 32'(data_out), 32'(e_dout));
        chk("r_id_out", 32'(r_id_out), 32'(e_id));
        chk("busy", 32'(busy), 32'(q.size() != 0 || ev.size() != 0));
        chk("overflow", 32'(overflow), 32'(e_ovf));
        chk("drop_count", 32'(drop_count), 32'(e_drops));
    endtask

    task automatic model_clear();
        q.delete();
        ev.delete();
        {e_rd, e_wr, e_rdy, e_ovf} = '0;
        e_addr = '0; e_wdata = '0; e_dout = '0; e_id = '0; e_drops = '0;
    endtask

    task automatic step(input logic rq, input logic [22:0] ad, input logic [5:0] id,
                        input logic we, input logic [22:0] wa, input logic [15:0] wd);
        int   pre;
        logic pop;
        rq_t  h;
        ev_t  e;
        req_available = rq; req_addr = ad; req_id = id;
        wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk);
        cyc++;
        pre = q.size();
        pop = !we && pre != 0;
        if (we) begin
            e_wr = 1'b1; e_rd = 1'b0; e_addr = wa; e_wdata = wd;
        end else if (pop) begin
            h = q.pop_front();
            e_wr = 1'b0; e_rd = 1'b1; e_addr = h.addr;
            ev.push_back('{ret: cyc + L + 1, id: h.id, addr: h.addr});
        end else begin
            e_wr = 1'b0; e_rd = 1'b0;
        end
        if (rq) begin
            if (pre < DEPTH || pop) q.push_back('{addr: ad, id: id});
            else begin
                e_ovf = 1'b1;
                if (e_drops != 8'hFF) e_drops++;
            end
        end
        e_rdy = 1'b0;
        if (ev.size() != 0 && ev[0].ret == cyc) begin
            e = ev.pop_front();
            e_rdy = 1'b1; e_dout = word(e.addr); e_id = e.id;
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        reset = 1'b0;
        req_available = 1'b0; req_addr = '0; req_id = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // single request, then the burst of ten
        step(1'b1, 23'h000102, 6'd5, 1'b0, '0, '0);
        idle(6);
        for (int i = 0; i < 10; i++) step(1'b1, 23'($urandom), 6'(i), 1'b0, '0, '0);
        idle(8);
        chk("burst_overflow", 32'(overflow), 32'd0);

        // writes block the queue: ten requests into eight slots
        for (int i = 0; i < 12; i++) step(i < 10, 23'($urandom), 6'(i), 1'b1, 23'($urandom), 16'($urandom));
        chk("ovf_drops", 32'(drop_count), 32'd2);
        chk("ovf_flag", 32'(overflow), 32'd1);
        idle(14);

        // full queue with a request landing in the pop cycle
        for (int i = 0; i < 8; i++) step(1'b1, 23'($urandom), 6'(i + 20), 1'b1, 23'($urandom), 16'($urandom));
        step(1'b1, 23'($urandom), 6'd40, 1'b0, '0, '0);
        chk("full_pop_drops", 32'(drop_count), 32'd2);
        idle(14);

        // write takes the RAM port ahead of a queued read
        step(1'b1, 23'h001234, 6'd9, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 23'h000010, 16'hBEEF);
        chk("wp_wdata", 32'(ram_wdata), 32'h0000BEEF);
        idle(6);

        // drop counter saturation
        for (int i = 0; i < 270; i++) step(1'b1, 23'($urandom), 6'($urandom), 1'b1, 23'($urandom), 16'($urandom));
        chk("sat_drops", 32'(drop_count), 32'd255);
        idle(14);

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 9) < 6, 23'($urandom), 6'($urandom),
                 $urandom_range(0, 4) == 0, 23'($urandom), 16'($urandom));
        idle(15);

        // async reset with three reads in flight and four queued
        for (int i = 0; i < 7; i++) step(1'b1, 23'($urandom), 6'(i), 1'b1, 23'($urandom), 16'($urandom));
        idle(3);
        chk("pre_rst_qlen", 32'(q.size()), 32'd4);
        #3;
        reset = 1'b0;
        #1;
        model_clear();
        check_all();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(8);
        chk("rst_drops", 32'(drop_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
